// File: rtl/uart_mem_pkg.sv
// Shared types and constants for the UART-side RAM sequencer: FSM state
// encoding, default command bytes and the bytes-per-word helper.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ADDR  = 3'd1,
        GET_CNT   = 3'd2,
        LOAD_BYTE = 3'd3,
        LOAD_WR   = 3'd4,
        DUMP_RD   = 3'd5,
        DUMP_TX   = 3'd6,
        FINISH    = 3'd7
    } state_e;

    localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;
    localparam logic [7:0] CMD_DUMP_DEF = 8'h44;

    function automatic int unsigned bpw(input int unsigned bit_width);
        return bit_width / 32'd8;
    endfunction

endpackage

// File: rtl/uart_word_shifter.sv
// Word-wide byte shift register with lane index: assembles little-endian words
// from incoming bytes and serialises a loaded word lane 0 first.
module uart_word_shifter
    import uart_mem_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [7:0]           byte_i,
    input  logic [BIT_WIDTH-1:0] word_i,
    output logic [BIT_WIDTH-1:0] word_o,
    output logic [7:0]           lane_o,
    output logic                 last_o
);

    localparam int unsigned BPW   = bpw(BIT_WIDTH);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [BIT_WIDTH-1:0] sh_q, sh_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    assign word_o = sh_q;
    assign lane_o = sh_q[7:0];
    assign last_o = (idx_q == IDX_W'(BPW - 1));

    // Next-state: bytes enter at the top lane so the first byte ends up in lane 0.
    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        if (clr_i) begin
            sh_d  = '0;
            idx_d = '0;
        end else if (load_i) begin
            sh_d  = word_i;
            idx_d = '0;
        end else if (shift_i) begin
            sh_d                  = sh_q >> 8;
            sh_d[BIT_WIDTH-1 -: 8] = byte_i;
            idx_d                 = last_o ? '0 : idx_q + IDX_W'(1);
        end else begin
            sh_d  = sh_q;
            idx_d = idx_q;
        end
    end

    // Shift register and lane index storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/uart_mem_ctrl.sv
// UART command sequencer for the RAM's UART port: parses load/dump frames,
// writes assembled words or streams words out, holding the CPU meanwhile.
module uart_mem_ctrl
    import uart_mem_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter logic [7:0]  CMD_LOAD   = CMD_LOAD_DEF,
    parameter logic [7:0]  CMD_DUMP   = CMD_DUMP_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] ADDR_UART,
    output logic [BIT_WIDTH-1:0]  WRITE_UART,
    output logic                  W_UART,
    input  logic [BIT_WIDTH-1:0]  READ_UART,
    output logic                  cpu_hold,
    output logic                  done
);

    // Wide enough for any count byte and for the 2^ADDR_WIDTH "zero" case.
    localparam int unsigned CNT_W = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  load_q, load_d;

    logic                  sh_clr_s, sh_load_s, sh_shift_s, sh_last_s;
    logic [7:0]            sh_byte_s, sh_lane_s;
    logic [BIT_WIDTH-1:0]  sh_word_s;
    logic                  last_word_s;

    assign last_word_s = (cnt_q == CNT_W'(1));
    assign sh_byte_s   = (state_q == DUMP_TX) ? 8'h00 : rx_data;

    uart_word_shifter #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (sh_clr_s),
        .load_i  (sh_load_s),
        .shift_i (sh_shift_s),
        .byte_i  (sh_byte_s),
        .word_i  (READ_UART),
        .word_o  (sh_word_s),
        .lane_o  (sh_lane_s),
        .last_o  (sh_last_s)
    );

    // Frame parser and transfer sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        sh_clr_s   = 1'b0;
        sh_load_s  = 1'b0;
        sh_shift_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == CMD_LOAD || rx_data == CMD_DUMP)) begin
                    state_d  = GET_ADDR;
                    load_d   = (rx_data == CMD_LOAD);
                    addr_d   = '0;
                    cnt_d    = '0;
                    sh_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_d  = ADDR_WIDTH'(rx_data);
                    state_d = GET_CNT;
                end else begin
                    state_d = GET_ADDR;
                end
            end
            GET_CNT: begin
                if (rx_valid) begin
                    cnt_d   = (rx_data == 8'h00) ? (CNT_W'(1) << ADDR_WIDTH) : CNT_W'(rx_data);
                    state_d = load_q ? LOAD_BYTE : DUMP_RD;
                end else begin
                    state_d = GET_CNT;
                end
            end
            LOAD_BYTE: begin
                sh_shift_s = rx_valid;
                if (rx_valid && sh_last_s) begin
                    state_d = LOAD_WR;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            LOAD_WR: begin
                // A byte arriving during the write cycle already belongs to the next word.
                addr_d     = addr_q + ADDR_WIDTH'(1);
                cnt_d      = cnt_q - CNT_W'(1);
                sh_shift_s = rx_valid && !last_word_s;
                if (last_word_s) begin
                    state_d = FINISH;
                end else if (rx_valid && sh_last_s) begin
                    state_d = LOAD_WR;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            DUMP_RD: begin
                sh_load_s = 1'b1;
                state_d   = DUMP_TX;
            end
            DUMP_TX: begin
                sh_shift_s = tx_ready;
                if (tx_ready && sh_last_s) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = last_word_s ? FINISH : DUMP_RD;
                end else begin
                    state_d = DUMP_TX;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, address, count and command-type registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    // Outputs decode only registered state, so reset forces them all low at once.
    assign W_UART     = (state_q == LOAD_WR);
    assign WRITE_UART = W_UART ? sh_word_s : '0;
    assign ADDR_UART  = (state_q == IDLE) ? '0 : addr_q;
    assign tx_valid   = (state_q == DUMP_TX);
    assign tx_data    = tx_valid ? sh_lane_s : 8'h00;
    assign cpu_hold   = (state_q != IDLE) && (state_q != FINISH);
    assign done       = (state_q == FINISH);

endmodule
